// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the packed-BCD incrementor.
//   DIGIT_W       : width of one BCD digit (nibble)
//   MAX_DIGIT     : largest legal BCD digit value
//   DIGITS_MIN/MAX: legal range for the DIGITS parameter of the top level
//   is_bcd_digit(): 1 when a nibble holds a legal decimal digit (0..9)
//   is_max_digit(): 1 when a nibble holds 9, the value that wraps on carry
// -----------------------------------------------------------------------------
package bcd_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam logic [3:0]  MAX_DIGIT  = 4'd9;
  localparam int unsigned DIGITS_MIN = 1;
  localparam int unsigned DIGITS_MAX = 8;

  typedef logic [DIGIT_W-1:0] digit_t;

  function automatic logic is_bcd_digit(input digit_t d);
    return (d <= MAX_DIGIT);
  endfunction

  function automatic logic is_max_digit(input digit_t d);
    return (d == MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_digit_inc.sv
// -----------------------------------------------------------------------------
// bcd_digit_inc
// Purely combinational single-digit BCD incrementor cell.
// Ports:
//   digit     [3:0] in  : BCD digit to increment
//   carry_in        in  : increment request from the lower digit
//   digit_out [3:0] out : incremented digit (digit passes through when no carry)
//   carry_out       out : digit wrapped 9 -> 0, propagate to the next digit
//   invalid         out : digit is not legal BCD (0xA..0xF)
// -----------------------------------------------------------------------------
module bcd_digit_inc
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       carry_in,
  output logic [3:0] digit_out,
  output logic       carry_out,
  output logic       invalid
);

  always_comb begin
    digit_out = digit;
    carry_out = 1'b0;
    invalid   = !is_bcd_digit(digit);
    // An illegal digit never generates a carry; the top level substitutes the
    // raw operand anyway, so this only keeps the chain quiet.
    if (carry_in && !invalid) begin
      if (is_max_digit(digit)) begin
        digit_out = 4'd0;
        carry_out = 1'b1;
      end else begin
        digit_out = digit + 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_incrementor.sv
// -----------------------------------------------------------------------------
// bcd_incrementor
// Adds one (in decimal) to a packed BCD operand, one result per cycle,
// single register stage between input sample and outputs.
// Parameters:
//   DIGITS : number of packed BCD digits (1..8)
// Ports:
//   clk                  in  : clock, rising edge
//   rst                  in  : synchronous active-high reset, beats in_valid
//   in_valid             in  : bcd_in is sampled on this edge
//   bcd_in  [4*DIGITS-1:0] in  : operand, digit 0 (units) in bits [3:0]
//   out_valid            out : outputs hold a fresh result this cycle
//   bcd_out [4*DIGITS-1:0] out : result, same digit order as bcd_in
//   overflow             out : all-9s operand wrapped to all-0s
//   bcd_err              out : some operand digit was > 9; bcd_out = bcd_in
// -----------------------------------------------------------------------------
module bcd_incrementor
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [DIGIT_W*DIGITS-1:0]   bcd_in,
  output logic                        out_valid,
  output logic [DIGIT_W*DIGITS-1:0]   bcd_out,
  output logic                        overflow,
  output logic                        bcd_err
);

  localparam int unsigned W = DIGIT_W * DIGITS;

  logic [DIGITS:0]   carry;
  logic [DIGITS-1:0] invalid;
  logic [W-1:0]      inc_sum;
  logic              any_invalid;
  logic [W-1:0]      next_out;
  logic              next_ovf;

  // Units digit always increments.
  assign carry[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_inc u_digit (
      .digit     (bcd_in[g*DIGIT_W +: DIGIT_W]),
      .carry_in  (carry[g]),
      .digit_out (inc_sum[g*DIGIT_W +: DIGIT_W]),
      .carry_out (carry[g+1]),
      .invalid   (invalid[g])
    );
  end

  assign any_invalid = |invalid;
  // A malformed operand is echoed untouched so the consumer can see what
  // arrived; overflow is meaningless in that case and forced low.
  assign next_out    = any_invalid ? bcd_in : inc_sum;
  assign next_ovf    = carry[DIGITS] & ~any_invalid;

  // ---- stage p1: result registers ----
  logic              vld_p1;
  logic [W-1:0]      bcd_p1;
  logic              ovf_p1;
  logic              err_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      bcd_p1 <= '0;
      ovf_p1 <= 1'b0;
      err_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      // Outputs keep the last result while no new operand arrives.
      if (in_valid) begin
        bcd_p1 <= next_out;
        ovf_p1 <= next_ovf;
        err_p1 <= any_invalid;
      end
    end
  end

  assign out_valid = vld_p1;
  assign bcd_out   = bcd_p1;
  assign overflow  = ovf_p1;
  assign bcd_err   = err_p1;

endmodule

// File: tb/tb_bcd_incrementor.sv
module tb_bcd_incrementor;

  localparam int DIGITS = 3;
  localparam int W      = 4 * DIGITS;
  localparam int MODN   = 10 ** DIGITS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] bcd_in;
  logic         out_valid;
  logic [W-1:0] bcd_out;
  logic         overflow;
  logic         bcd_err;

  int total = 0;
  int bad   = 0;

  // expected outputs, maintained by the reference model
  logic         m_vld;
  logic [W-1:0] m_out;
  logic         m_ovf;
  logic         m_err;

  bcd_incrementor #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .bcd_in    (bcd_in),
    .out_valid (out_valid),
    .bcd_out   (bcd_out),
    .overflow  (overflow),
    .bcd_err   (bcd_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Decimal reference: decode, add one arithmetically, wrap modulo 10^DIGITS.
  task automatic ref_model(input logic [W-1:0] x, output logic [W-1:0] o,
                           output logic ov, output logic er);
    int v;
    int scale;
    er = 1'b0;
    v = 0;
    scale = 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (int'(x[4*i +: 4]) > 9) er = 1'b1;
      v = v + int'(x[4*i +: 4]) * scale;
      scale = scale * 10;
    end
    if (er) begin
      o  = x;
      ov = 1'b0;
    end else begin
      ov = (v + 1 == MODN);
      o  = int2bcd((v + 1) % MODN);
    end
  endtask

  task automatic chk(input string tag, input logic v, input logic [W-1:0] o,
                     input logic ov, input logic er);
    total++;
    assert (out_valid === v) else begin
      bad++;
      $error("FAIL %s out_valid got=%0b exp=%0b", tag, out_valid, v);
    end
    total++;
    assert (bcd_out === o) else begin
      bad++;
      $error("FAIL %s bcd_out got=%h exp=%h", tag, bcd_out, o);
    end
    total++;
    assert (overflow === ov) else begin
      bad++;
      $error("FAIL %s overflow got=%0b exp=%0b", tag, overflow, ov);
    end
    total++;
    assert (bcd_err === er) else begin
      bad++;
      $error("FAIL %s bcd_err got=%0b exp=%0b", tag, bcd_err, er);
    end
  endtask

  // Drive one cycle, update the model from the behavioural rules, sample
  // 1 time unit after the active edge.
  task automatic step(input logic r, input logic v, input logic [W-1:0] d);
    logic [W-1:0] o;
    logic ov, er;
    @(negedge clk);
    rst = r;
    in_valid = v;
    bcd_in = d;
    if (r) begin
      m_vld = 1'b0; m_out = '0; m_ovf = 1'b0; m_err = 1'b0;
    end else if (v) begin
      ref_model(d, o, ov, er);
      m_vld = 1'b1; m_out = o; m_ovf = ov; m_err = er;
    end else begin
      m_vld = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    bcd_in = '0;
    m_vld = 1'b0; m_out = '0; m_ovf = 1'b0; m_err = 1'b0;

    step(1'b1, 1'b0, 12'h000);
    step(1'b1, 1'b0, 12'h000);
    chk("reset", 1'b0, 12'h000, 1'b0, 1'b0);

    step(1'b0, 1'b1, 12'h259);
    chk("inc_259", 1'b1, 12'h260, 1'b0, 1'b0);
    step(1'b0, 1'b1, 12'h009);
    chk("inc_009", 1'b1, 12'h010, 1'b0, 1'b0);
    step(1'b0, 1'b1, 12'h199);
    chk("inc_199", 1'b1, 12'h200, 1'b0, 1'b0);
    step(1'b0, 1'b1, 12'h999);
    chk("wrap_999", 1'b1, 12'h000, 1'b1, 1'b0);
    step(1'b0, 1'b1, 12'h000);
    chk("inc_000", 1'b1, 12'h001, 1'b0, 1'b0);
    step(1'b0, 1'b1, 12'h2A5);
    chk("invalid_2A5", 1'b1, 12'h2A5, 1'b0, 1'b1);
    step(1'b0, 1'b1, 12'hF99);
    chk("invalid_F99", 1'b1, 12'hF99, 1'b0, 1'b1);

    // hold behaviour after in_valid drops
    step(1'b0, 1'b1, 12'h259);
    chk("hold_load", 1'b1, 12'h260, 1'b0, 1'b0);
    step(1'b0, 1'b0, 12'h777);
    chk("hold_1", 1'b0, 12'h260, 1'b0, 1'b0);
    step(1'b0, 1'b0, 12'h999);
    chk("hold_2", 1'b0, 12'h260, 1'b0, 1'b0);

    // overflow flag must hold while idle too
    step(1'b0, 1'b1, 12'h999);
    step(1'b0, 1'b0, 12'h000);
    chk("hold_ovf", 1'b0, 12'h000, 1'b1, 1'b0);

    // reset beats in_valid
    step(1'b1, 1'b1, 12'h123);
    chk("rst_prio", 1'b0, 12'h000, 1'b0, 1'b0);

    // reset right after an accepted input discards that result
    step(1'b0, 1'b1, 12'h123);
    chk("pre_discard", 1'b1, 12'h124, 1'b0, 1'b0);
    step(1'b0, 1'b1, 12'h456);
    step(1'b1, 1'b0, 12'h000);
    chk("discard", 1'b0, 12'h000, 1'b0, 1'b0);

    // exhaustive, back-to-back
    for (int i = 0; i < MODN; i++) begin
      step(1'b0, 1'b1, int2bcd(i));
      chk("exhaustive", m_vld, m_out, m_ovf, m_err);
    end

    // random operands (including illegal nibbles) with random gaps
    for (int i = 0; i < 400; i++) begin
      step(1'b0, ($urandom_range(0, 3) != 0), W'($urandom));
      chk("random", m_vld, m_out, m_ovf, m_err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
